// File: rtl/alarm_set_compare_if.sv
// Mode/button/time inputs and alarm-state outputs between the mode FSM,
// the time-of-day counter, and the alarm compare stage.
interface alarm_set_compare_if;

    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;

    // inputs to the alarm stage
    logic              ALM_HOUR;
    logic              ALM_MIN;
    logic              ALM_ONOFF;
    logic              SW_F2;
    logic              SEC_TICK;
    logic [HOUR_W-1:0] CUR_HOUR;
    logic [MIN_W-1:0]  CUR_MIN;
    logic [SEC_W-1:0]  CUR_SEC;

    // outputs of the alarm stage
    logic [HOUR_W-1:0] ALM_HOUR_VAL;
    logic [MIN_W-1:0]  ALM_MIN_VAL;
    logic              ALM_EN;
    logic              BUZZ;
    logic              SNOOZING;

    // upstream side: mode FSM, button, clock counter; consumes alarm state
    modport master (
        output ALM_HOUR, ALM_MIN, ALM_ONOFF, SW_F2, SEC_TICK,
        output CUR_HOUR, CUR_MIN, CUR_SEC,
        input  ALM_HOUR_VAL, ALM_MIN_VAL, ALM_EN, BUZZ, SNOOZING
    );

    // alarm stage side
    modport slave (
        input  ALM_HOUR, ALM_MIN, ALM_ONOFF, SW_F2, SEC_TICK,
        input  CUR_HOUR, CUR_MIN, CUR_SEC,
        output ALM_HOUR_VAL, ALM_MIN_VAL, ALM_EN, BUZZ, SNOOZING
    );

endinterface

// File: rtl/alarm_set_compare.sv
// Alarm set/compare stage: holds the alarm time and enable, adjusts them
// from the SW_F2 button in the active set mode, compares against the running
// clock on each second tick, and sequences the buzzer through ring/snooze.
module alarm_set_compare #(
    parameter int unsigned RST_HOUR   = 7,
    parameter int unsigned RST_MIN    = 0,
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned MAX_SNOOZE = 3
) (
    input logic              CLK,
    input logic              RST,
    alarm_set_compare_if.slave bus
);

    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;

    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned MIN_MAX  = 59;

    // Counter widths; the snooze-count width is floored at 1 so that
    // MAX_SNOOZE=0 still yields a legal vector.
    localparam int unsigned RING_W  = $clog2(RING_SEC + 1);
    localparam int unsigned SNZ_W   = $clog2(SNOOZE_SEC + 1);
    localparam int unsigned NUM_W_R = $clog2(MAX_SNOOZE + 1);
    localparam int unsigned NUM_W   = (NUM_W_R == 0) ? 1 : NUM_W_R;

    localparam logic [HOUR_W-1:0] RST_HOUR_V = HOUR_W'(RST_HOUR);
    localparam logic [MIN_W-1:0]  RST_MIN_V  = MIN_W'(RST_MIN);
    localparam logic [HOUR_W-1:0] HOUR_LAST  = HOUR_W'(HOUR_MAX);
    localparam logic [MIN_W-1:0]  MIN_LAST   = MIN_W'(MIN_MAX);

    // Count value held just before the tick that completes a period.
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SEC - 1);
    localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_SEC - 1);
    localparam logic [NUM_W-1:0]  NUM_LIMIT = NUM_W'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    state_t              state_q;
    logic                sw_f2_q;
    logic [HOUR_W-1:0]   hour_q;
    logic [MIN_W-1:0]    min_q;
    logic                en_q;
    logic [RING_W-1:0]   ring_cnt_q;
    logic [SNZ_W-1:0]    snz_cnt_q;
    logic [NUM_W-1:0]    snz_num_q;
    logic                buzz_q;
    logic                snoozing_q;

    logic                press_c;
    logic                match_c;
    logic [HOUR_W-1:0]   hour_inc_c;
    logic [MIN_W-1:0]    min_inc_c;

    // Rising edge of the debounced button; a held level never repeats.
    assign press_c = bus.SW_F2 & ~sw_f2_q;

    // Trigger on the HH:MM:00 tick, using the register values before any
    // same-cycle adjust lands.
    assign match_c = en_q & bus.SEC_TICK
                   & (bus.CUR_HOUR == hour_q)
                   & (bus.CUR_MIN  == min_q)
                   & (bus.CUR_SEC  == SEC_W'(0));

    // Wrapping increments for the alarm time fields; no minute->hour carry.
    assign hour_inc_c = (hour_q == HOUR_LAST) ? '0 : hour_q + HOUR_W'(1);
    assign min_inc_c  = (min_q  == MIN_LAST)  ? '0 : min_q  + MIN_W'(1);

    // Button history register for edge detection.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sw_f2_q <= 1'b0;
        end else begin
            sw_f2_q <= bus.SW_F2;
        end
    end

    // Alarm time and enable adjust; only honoured while idle, with
    // hour > minute > on/off mode priority.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hour_q <= RST_HOUR_V;
            min_q  <= RST_MIN_V;
            en_q   <= 1'b0;
        end else if (press_c && (state_q == IDLE)) begin
            if (bus.ALM_HOUR) begin
                hour_q <= hour_inc_c;
            end else if (bus.ALM_MIN) begin
                min_q <= min_inc_c;
            end else if (bus.ALM_ONOFF) begin
                en_q <= ~en_q;
            end
        end
    end

    // Ring/snooze sequencer with registered BUZZ and SNOOZING that track
    // the state one-for-one. A press outranks a same-cycle final tick.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            snz_num_q  <= '0;
            buzz_q     <= 1'b0;
            snoozing_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (match_c) begin
                        state_q    <= RINGING;
                        ring_cnt_q <= '0;
                        snz_num_q  <= '0;
                        buzz_q     <= 1'b1;
                        snoozing_q <= 1'b0;
                    end
                end

                RINGING: begin
                    if (press_c) begin
                        if (snz_num_q < NUM_LIMIT) begin
                            state_q    <= SNOOZE;
                            snz_num_q  <= snz_num_q + NUM_W'(1);
                            snz_cnt_q  <= '0;
                            buzz_q     <= 1'b0;
                            snoozing_q <= 1'b1;
                        end else begin
                            state_q    <= IDLE;
                            buzz_q     <= 1'b0;
                            snoozing_q <= 1'b0;
                        end
                    end else if (bus.SEC_TICK) begin
                        if (ring_cnt_q == RING_LAST) begin
                            state_q    <= IDLE;
                            buzz_q     <= 1'b0;
                            snoozing_q <= 1'b0;
                        end else begin
                            ring_cnt_q <= ring_cnt_q + RING_W'(1);
                        end
                    end
                end

                SNOOZE: begin
                    if (press_c) begin
                        state_q    <= IDLE;
                        buzz_q     <= 1'b0;
                        snoozing_q <= 1'b0;
                    end else if (bus.SEC_TICK) begin
                        if (snz_cnt_q == SNZ_LAST) begin
                            state_q    <= RINGING;
                            ring_cnt_q <= '0;
                            buzz_q     <= 1'b1;
                            snoozing_q <= 1'b0;
                        end else begin
                            snz_cnt_q <= snz_cnt_q + SNZ_W'(1);
                        end
                    end
                end

                default: begin
                    state_q    <= IDLE;
                    buzz_q     <= 1'b0;
                    snoozing_q <= 1'b0;
                end
            endcase
        end
    end

    // Output drive from the registers above.
    assign bus.ALM_HOUR_VAL = hour_q;
    assign bus.ALM_MIN_VAL  = min_q;
    assign bus.ALM_EN       = en_q;
    assign bus.BUZZ         = buzz_q;
    assign bus.SNOOZING     = snoozing_q;

endmodule

// File: tb/tb_alarm_set_compare.sv
// Directed bench for alarm_set_compare: adjust/wrap, ring timeout, snooze,
// same-cycle collisions and asynchronous reset mid-ring / mid-snooze.
module tb_alarm_set_compare;

    localparam int unsigned RING_SEC   = 3;
    localparam int unsigned SNOOZE_SEC = 2;
    localparam int unsigned MAX_SNOOZE = 1;

    logic CLK;
    logic RST;
    int   n_checks;
    int   n_errors;

    alarm_set_compare_if bus ();

    alarm_set_compare #(
        .RST_HOUR   (7),
        .RST_MIN    (0),
        .RING_SEC   (RING_SEC),
        .SNOOZE_SEC (SNOOZE_SEC),
        .MAX_SNOOZE (MAX_SNOOZE)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic press();
        bus.SW_F2 = 1'b1;
        step();
        bus.SW_F2 = 1'b0;
        step();
    endtask

    task automatic press_n(input int n);
        for (int i = 0; i < n; i++) press();
    endtask

    task automatic tick(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        bus.CUR_HOUR = h;
        bus.CUR_MIN  = m;
        bus.CUR_SEC  = s;
        bus.SEC_TICK = 1'b1;
        step();
        bus.SEC_TICK = 1'b0;
    endtask

    task automatic set_mode(input logic h, input logic m, input logic o);
        bus.ALM_HOUR  = h;
        bus.ALM_MIN   = m;
        bus.ALM_ONOFF = o;
    endtask

    task automatic check_out(input string tag, input int buzz, input int snz);
        check({tag, "_buzz"}, 32'(bus.BUZZ), 32'(buzz));
        check({tag, "_snz"},  32'(bus.SNOOZING), 32'(snz));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        RST = 1'b1;
        set_mode(1'b0, 1'b0, 1'b0);
        bus.SW_F2    = 1'b0;
        bus.SEC_TICK = 1'b0;
        bus.CUR_HOUR = '0;
        bus.CUR_MIN  = '0;
        bus.CUR_SEC  = '0;
        step();
        step();
        RST = 1'b0;
        step();

        // reset state
        check("rst_hour", 32'(bus.ALM_HOUR_VAL), 32'd7);
        check("rst_min",  32'(bus.ALM_MIN_VAL),  32'd0);
        check("rst_en",   32'(bus.ALM_EN),       32'd0);
        check_out("rst", 0, 0);

        // hour wrap: 7 + 17 = 24 -> 0
        set_mode(1'b1, 1'b0, 1'b0);
        press_n(17);
        check("hour_wrap", 32'(bus.ALM_HOUR_VAL), 32'd0);

        // minute wrap: 0 + 61 -> 1, no carry into hour
        set_mode(1'b0, 1'b1, 1'b0);
        press_n(61);
        check("min_wrap", 32'(bus.ALM_MIN_VAL), 32'd1);
        check("min_wrap_hour", 32'(bus.ALM_HOUR_VAL), 32'd0);

        // held button -> single increment
        bus.SW_F2 = 1'b1;
        for (int i = 0; i < 10; i++) step();
        bus.SW_F2 = 1'b0;
        step();
        check("held_min", 32'(bus.ALM_MIN_VAL), 32'd2);

        // all modes active: hour wins
        set_mode(1'b1, 1'b1, 1'b1);
        press();
        check("prio_hour", 32'(bus.ALM_HOUR_VAL), 32'd1);
        check("prio_min",  32'(bus.ALM_MIN_VAL),  32'd2);
        check("prio_en",   32'(bus.ALM_EN),       32'd0);

        // set alarm to 06:30, armed
        set_mode(1'b1, 1'b0, 1'b0);
        press_n(5);
        set_mode(1'b0, 1'b1, 1'b0);
        press_n(28);
        set_mode(1'b0, 1'b0, 1'b1);
        press();
        set_mode(1'b0, 1'b0, 1'b0);
        press();
        check("set_hour", 32'(bus.ALM_HOUR_VAL), 32'd6);
        check("set_min",  32'(bus.ALM_MIN_VAL),  32'd30);
        check("set_en",   32'(bus.ALM_EN),       32'd1);

        // no trigger off second zero
        tick(5'd6, 6'd30, 6'd5);
        check_out("sec_nz", 0, 0);

        // ring timeout after RING_SEC ticks
        tick(5'd6, 6'd30, 6'd0);
        check_out("trig", 1, 0);
        step();
        check_out("ring_idle_cyc", 1, 0);
        tick(5'd6, 6'd30, 6'd1);
        check_out("ring_t1", 1, 0);
        tick(5'd6, 6'd30, 6'd2);
        check_out("ring_t2", 1, 0);
        tick(5'd6, 6'd30, 6'd3);
        check_out("ring_t3", 0, 0);
        check("ring_en_kept", 32'(bus.ALM_EN), 32'd1);
        tick(5'd6, 6'd30, 6'd1);
        check_out("no_retrig", 0, 0);

        // snooze then re-ring; on/off mode press while ringing leaves EN alone
        tick(5'd6, 6'd30, 6'd0);
        check_out("snz_trig", 1, 0);
        set_mode(1'b0, 1'b0, 1'b1);
        press();
        check_out("snz_enter", 0, 1);
        check("onoff_ring_en", 32'(bus.ALM_EN), 32'd1);
        tick(5'd6, 6'd30, 6'd2);
        check_out("snz_t1", 0, 1);
        tick(5'd6, 6'd30, 6'd3);
        check_out("snz_t2", 1, 0);
        press();
        check_out("snz_max", 0, 0);
        check("onoff_snz_en", 32'(bus.ALM_EN), 32'd1);
        set_mode(1'b0, 1'b0, 1'b0);

        // cancel from snooze
        tick(5'd6, 6'd30, 6'd0);
        press();
        check_out("cancel_snz", 0, 1);
        press();
        check_out("cancel_idle", 0, 0);

        // press in hour mode on the match cycle: triggers on old value, hour+1
        set_mode(1'b1, 1'b0, 1'b0);
        bus.SW_F2 = 1'b1;
        tick(5'd6, 6'd30, 6'd0);
        bus.SW_F2 = 1'b0;
        step();
        set_mode(1'b0, 1'b0, 1'b0);
        check_out("coll_match", 1, 0);
        check("coll_hour", 32'(bus.ALM_HOUR_VAL), 32'd7);

        // press on the final ring tick with snooze available -> SNOOZE
        tick(5'd7, 6'd30, 6'd1);
        tick(5'd7, 6'd30, 6'd2);
        bus.SW_F2 = 1'b1;
        tick(5'd7, 6'd30, 6'd3);
        bus.SW_F2 = 1'b0;
        step();
        check_out("coll_ring_end", 0, 1);

        // press on the final snooze tick -> IDLE
        tick(5'd7, 6'd30, 6'd4);
        bus.SW_F2 = 1'b1;
        tick(5'd7, 6'd30, 6'd5);
        bus.SW_F2 = 1'b0;
        step();
        check_out("coll_snz_end", 0, 0);

        // asynchronous reset mid-ring
        tick(5'd7, 6'd30, 6'd0);
        check_out("pre_rst_ring", 1, 0);
        RST = 1'b1;
        #1;
        check_out("rst_ring", 0, 0);
        check("rst_ring_hour", 32'(bus.ALM_HOUR_VAL), 32'd7);
        check("rst_ring_min",  32'(bus.ALM_MIN_VAL),  32'd0);
        check("rst_ring_en",   32'(bus.ALM_EN),       32'd0);
        step();
        RST = 1'b0;
        step();

        // asynchronous reset mid-snooze (alarm now 07:00)
        set_mode(1'b0, 1'b0, 1'b1);
        press();
        set_mode(1'b0, 1'b0, 1'b0);
        tick(5'd7, 6'd0, 6'd0);
        press();
        check_out("pre_rst_snz", 0, 1);
        RST = 1'b1;
        #1;
        check_out("rst_snz", 0, 0);
        check("rst_snz_en", 32'(bus.ALM_EN), 32'd0);
        step();
        RST = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alarm_set_compare.md
Name: alarm_set_compare

Overview:
- Downstream stage of the alarm-control mode FSM.
- Consumes the one-hot mode indicators ALM_HOUR / ALM_MIN / ALM_ONOFF and the SW_F2 adjust button.
- Holds the alarm time and enable, compares them with the running clock time, and drives the buzzer through a ring/snooze state machine.
- Output feeds the display mux (alarm time, enable) and the buzzer driver.

Parameters:
RST_HOUR, 7, alarm hour loaded at reset (0-23)
RST_MIN, 0, alarm minute loaded at reset (0-59)
RING_SEC, 60, seconds BUZZ stays on per ring period (>=1)
SNOOZE_SEC, 300, snooze length in seconds (>=1)
MAX_SNOOZE, 3, snoozes allowed per alarm event (>=0)

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-high
ALM_HOUR  in  1  alarm-hour set mode active
ALM_MIN  in  1  alarm-minute set mode active
ALM_ONOFF  in  1  alarm on/off mode active
SW_F2  in  1  adjust button level, debounced, synchronous to CLK
SEC_TICK  in  1  one-CLK pulse per second
CUR_HOUR  in  5  current hour, binary 0-23
CUR_MIN  in  6  current minute, binary 0-59
CUR_SEC  in  6  current second, binary 0-59
ALM_HOUR_VAL  out  5  stored alarm hour
ALM_MIN_VAL  out  6  stored alarm minute
ALM_EN  out  1  alarm armed
BUZZ  out  1  buzzer on
SNOOZING  out  1  snooze in progress

Behaviour:
Reset (asynchronous, RST=1):
- ALM_HOUR_VAL=RST_HOUR, ALM_MIN_VAL=RST_MIN.
- ALM_EN=0, BUZZ=0, SNOOZING=0.
- State=IDLE; ring, snooze and snooze-count counters=0; edge register=0.
- Reset asserted mid-ring or mid-snooze aborts immediately; no residual BUZZ.

Button edge detection:
- press = SW_F2 & ~SW_F2_q, where SW_F2_q is SW_F2 registered.
- One press per rising edge. A held button never repeats.

Adjust (state IDLE only), effect visible the cycle after press:
- Mode priority: ALM_HOUR > ALM_MIN > ALM_ONOFF. No mode active: press ignored.
- Hour mode: hour+1, wraps 23 -> 0.
- Minute mode: minute+1, wraps 59 -> 0, no carry into hour.
- On/off mode: ALM_EN toggles.
- In RINGING or SNOOZE, presses go to the FSM only; alarm values and ALM_EN never change.

Match:
- match = ALM_EN & SEC_TICK & CUR_HOUR==ALM_HOUR_VAL & CUR_MIN==ALM_MIN_VAL & CUR_SEC==0.
- Evaluated with pre-update register values. If a press and a match occur in the same cycle, the press updates the registers and the trigger still uses the old values.

FSM states: IDLE, RINGING, SNOOZE. All outputs are registered.
- IDLE -> RINGING on match. Ring counter=0, snooze count=0. BUZZ=1 from the next cycle.
- RINGING:
  - Each SEC_TICK increments the ring counter. The trigger tick is not counted.
  - On the tick that brings the count to RING_SEC: -> IDLE, BUZZ=0 next cycle.
  - On press with snooze count < MAX_SNOOZE: -> SNOOZE, snooze count+1, snooze counter=0.
  - On press with snooze count == MAX_SNOOZE: -> IDLE.
  - Press and final tick in the same cycle: press wins.
- SNOOZE:
  - BUZZ=0, SNOOZING=1.
  - Each SEC_TICK increments the snooze counter. On the tick reaching SNOOZE_SEC: -> RINGING, ring counter=0.
  - Press -> IDLE (cancel). Press and final tick in the same cycle: press wins (-> IDLE).
- BUZZ=1 exactly while state==RINGING. SNOOZING=1 exactly while state==SNOOZE.

Re-trigger and enable:
- No re-trigger outside IDLE.
- After returning to IDLE, a new trigger needs a fresh HH:MM:00 tick.
- ALM_EN remains 1 after the ring ends (daily alarm).

Counter widths:
- Sized by $clog2 of RING_SEC, SNOOZE_SEC and MAX_SNOOZE, each plus 1.
- Counters never wrap in legal operation.

Test Plan:
- Reset at alarm values 07:00, EN=0 -> after RST deassert outputs 7/0/0, BUZZ=0, SNOOZING=0.
- Adjust wrap: ALM_HOUR=1 with 17 presses from 07 -> hour 0. ALM_MIN=1 with 61 presses from 0 -> minute 1, hour unchanged. Held SW_F2 for 10 cycles -> single increment.
- Ring timeout (RING_SEC=3):
  - EN=1, alarm 06:30, tick at CUR 06:30:00 -> BUZZ=1 next cycle.
  - After 3 further ticks -> BUZZ=0, ALM_EN still 1.
  - Tick at 06:30:01 -> no trigger.
- Snooze (SNOOZE_SEC=2, MAX_SNOOZE=1):
  - Press while ringing -> BUZZ=0, SNOOZING=1.
  - After 2 ticks -> BUZZ=1.
  - Second press -> IDLE, BUZZ=0, SNOOZING=0.
- Collisions:
  - Press in hour mode on the same cycle as a match -> BUZZ=1 and hour+1.
  - Press on the final ring tick with snooze available -> SNOOZE, not IDLE.
  - Press in ALM_ONOFF mode while ringing -> ALM_EN unchanged.
- Reset mid-RINGING and mid-SNOOZE -> BUZZ=0, SNOOZING=0 asynchronously, before the next CLK edge. Alarm values return to RST_HOUR/RST_MIN.
